// File: rtl/fmac_rx_hdr_extract.sv
// fmac_rx_hdr_extract: pull DA/SA/EtherType out of the 64-bit RX beat stream and
// issue them on a paced strobe for the downstream source-address filter.
//   clk, rst           : single clock, synchronous active-high reset
//   rx_data/vld/sop/eop/be : MAC RX beats, byte 0 at rx_data[63:56]
//   mac_daddr/saddr/etype  : last issued header, held between issues
//   mac_saddr_vld      : one-cycle strobe, at least MIN_GAP cycles apart
//   hdr_runt, hdr_ovf  : one-cycle error pulses (short frame, dropped header)
//   hdr_cnt            : saturating count of issued headers
module fmac_rx_hdr_extract #(
    parameter int MIN_GAP = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] rx_data,
    input  logic        rx_vld,
    input  logic        rx_sop,
    input  logic        rx_eop,
    input  logic [7:0]  rx_be,
    output logic [47:0] mac_daddr,
    output logic [47:0] mac_saddr,
    output logic [15:0] mac_etype,
    output logic        mac_saddr_vld,
    output logic        hdr_runt,
    output logic        hdr_ovf,
    output logic [15:0] hdr_cnt
);
    typedef enum logic [1:0] {IDLE, HDR1, BODY} state_t;
    localparam logic [3:0] GAP_LD = 4'(MIN_GAP - 1);
    state_t       r_state;
    logic [47:0]  r_da;
    logic [15:0]  r_sa_hi;
    logic [111:0] r_pend;
    logic         r_pend_vld;
    logic [3:0]   r_gap;
    logic         w_short, w_hdr1, w_done, w_runt, w_gap_zero;
    logic         w_iss_pend, w_iss_new, w_issue, w_load_pend, w_ovf;
    logic [111:0] w_hdr, w_iss_hdr;
    logic         w_unused;
    assign w_unused    = &{1'b0, rx_be[1:0]};
    // second beat must carry header bytes 8..13 (be[7:2]) to complete the header
    assign w_short     = rx_eop & ~&rx_be[7:2];
    assign w_hdr1      = r_state == HDR1;
    assign w_done      = rx_vld & ~rx_sop & w_hdr1 & ~w_short;
    assign w_runt      = rx_vld & (rx_sop ? (rx_eop | w_hdr1) : (w_hdr1 & w_short));
    // SA[31:0] and EtherType sit contiguously in rx_data[63:16] of the second beat
    assign w_hdr       = {r_da, r_sa_hi, rx_data[63:16]};
    assign w_gap_zero  = r_gap == 4'd0;
    assign w_iss_pend  = r_pend_vld & w_gap_zero;
    assign w_iss_new   = w_done & ~r_pend_vld & w_gap_zero;
    assign w_issue     = w_iss_pend | w_iss_new;
    assign w_iss_hdr   = w_iss_pend ? r_pend : w_hdr;
    // the slot takes a new header if it is empty and blocked, or is being freed now
    assign w_load_pend = w_done & (w_iss_pend | (~r_pend_vld & ~w_gap_zero));
    assign w_ovf       = w_done & r_pend_vld & ~w_iss_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_pend_vld    <= 1'b0;
            r_gap         <= 4'd0;
            mac_daddr     <= 48'd0;
            mac_saddr     <= 48'd0;
            mac_etype     <= 16'd0;
            mac_saddr_vld <= 1'b0;
            hdr_runt      <= 1'b0;
            hdr_ovf       <= 1'b0;
            hdr_cnt       <= 16'd0;
        end else begin
            if (rx_vld) begin
                if (rx_sop) begin
                    r_da    <= rx_data[63:16];
                    r_sa_hi <= rx_data[15:0];
                    r_state <= rx_eop ? IDLE : HDR1;
                end else if (r_state == HDR1) begin
                    r_state <= rx_eop ? IDLE : BODY;
                end else if (r_state == BODY && rx_eop) begin
                    r_state <= IDLE;
                end
            end
            r_pend_vld <= w_load_pend | (r_pend_vld & ~w_iss_pend);
            if (w_load_pend) r_pend <= w_hdr;
            r_gap <= w_issue ? GAP_LD : r_gap - {3'd0, ~w_gap_zero};
            if (w_issue) {mac_daddr, mac_saddr, mac_etype} <= w_iss_hdr;
            if (w_issue && hdr_cnt != 16'hFFFF) hdr_cnt <= hdr_cnt + 16'd1;
            mac_saddr_vld <= w_issue;
            hdr_runt      <= w_runt;
            hdr_ovf       <= w_ovf;
        end
    end
endmodule

// File: tb/tb_fmac_rx_hdr_extract.sv
// tb_fmac_rx_hdr_extract: scoreboard bench with a byte-stream reference model.
module tb_fmac_rx_hdr_extract;
    localparam int MIN_GAP = 3;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] rx_data = 64'd0;
    logic        rx_vld = 1'b0, rx_sop = 1'b0, rx_eop = 1'b0;
    logic [7:0]  rx_be = 8'hFF;
    logic [47:0] mac_daddr, mac_saddr;
    logic [15:0] mac_etype, hdr_cnt;
    logic        mac_saddr_vld, hdr_runt, hdr_ovf;

    fmac_rx_hdr_extract #(.MIN_GAP(MIN_GAP)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_vld(rx_vld), .rx_sop(rx_sop),
        .rx_eop(rx_eop), .rx_be(rx_be), .mac_daddr(mac_daddr), .mac_saddr(mac_saddr),
        .mac_etype(mac_etype), .mac_saddr_vld(mac_saddr_vld), .hdr_runt(hdr_runt),
        .hdr_ovf(hdr_ovf), .hdr_cnt(hdr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           e;
        logic [111:0] h;
        logic [15:0]  cnt;
    } iss_t;

    iss_t         iq[$];
    int           rq[$];
    int           oq[$];
    int           n_chk = 0, n_err = 0;
    int           ecnt = 0;
    bit           mon_en = 1'b0;
    bit           in_frame = 1'b0;
    int           nb = 0;
    logic [7:0]   hb[14];
    int           last_iss = -1000;
    bit           wv = 1'b0;
    logic [111:0] wh = '0;
    logic [111:0] m_out = '0;
    logic [15:0]  m_cnt = '0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @edge %0d: got %h expected %h", nm, ecnt, act, exp);
        end
    endtask

    task automatic issue(input int e, input logic [111:0] h);
        if (m_cnt != 16'hFFFF) m_cnt++;
        m_out = h;
        last_iss = e;
        iq.push_back('{e, h, m_cnt});
    endtask

    // Reference: frames are byte streams; the header is bytes 0..13, and issues
    // are spaced MIN_GAP edges apart with a single waiting slot (oldest wins).
    always @(posedge clk) begin
        automatic bit done = 1'b0, runt = 1'b0;
        automatic logic [111:0] nh = '0;
        automatic int nbytes = 8;
        ecnt++;
        if (rst) begin
            in_frame = 1'b0; nb = 0; wv = 1'b0; last_iss = -1000;
            m_out = '0; m_cnt = '0;
        end else begin
            if (rx_vld) begin
                if (rx_sop) begin
                    if (in_frame && nb < 14) runt = 1'b1;
                    in_frame = 1'b1;
                    nb = 0;
                end
                if (in_frame) begin
                    if (rx_eop) nbytes = $countones(rx_be);
                    for (int i = 0; i < nbytes; i++) begin
                        if (nb < 14) begin
                            hb[nb] = rx_data[63-8*i -: 8];
                            nb++;
                            if (nb == 14) done = 1'b1;
                        end
                    end
                    if (rx_eop) begin
                        if (nb < 14) runt = 1'b1;
                        in_frame = 1'b0;
                    end
                end
            end
            if (done) for (int i = 0; i < 14; i++) nh = {nh[103:0], hb[i]};
            if (runt) rq.push_back(ecnt);
            if ((ecnt - last_iss) >= MIN_GAP && wv) begin
                issue(ecnt, wh);
                wv = done;
                wh = nh;
            end else if ((ecnt - last_iss) >= MIN_GAP && done) begin
                issue(ecnt, nh);
            end else if (done) begin
                if (!wv) begin
                    wv = 1'b1;
                    wh = nh;
                end else oq.push_back(ecnt);
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            automatic bit exp_v, exp_r, exp_o;
            while (iq.size() != 0 && iq[0].e < ecnt) begin
                n_chk++; n_err++;
                $display("FAIL missed_vld @edge %0d: got none expected header issued at edge %0d", ecnt, iq[0].e);
                void'(iq.pop_front());
            end
            exp_v = iq.size() != 0 && iq[0].e == ecnt;
            chk("vld", 128'(mac_saddr_vld), 128'(exp_v));
            if (exp_v) begin
                chk("hdr", 128'({mac_daddr, mac_saddr, mac_etype}), 128'(iq[0].h));
                chk("cnt_at_vld", 128'(hdr_cnt), 128'(iq[0].cnt));
                void'(iq.pop_front());
            end
            exp_r = rq.size() != 0 && rq[0] == ecnt;
            if (exp_r) void'(rq.pop_front());
            chk("runt", 128'(hdr_runt), 128'(exp_r));
            exp_o = oq.size() != 0 && oq[0] == ecnt;
            if (exp_o) void'(oq.pop_front());
            chk("ovf", 128'(hdr_ovf), 128'(exp_o));
            chk("hold", 128'({mac_daddr, mac_saddr, mac_etype}), 128'(m_out));
            chk("hdr_cnt", 128'(hdr_cnt), 128'(m_cnt));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic beat(input logic [63:0] d, input logic s, input logic e, input logic [7:0] be);
        rx_data = d; rx_sop = s; rx_eop = e; rx_be = be; rx_vld = 1'b1;
        step();
        rx_vld = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0; rx_be = 8'hFF;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic frame2();
        beat(rnd64(), 1'b1, 1'b0, 8'hFF);
        beat(rnd64(), 1'b0, 1'b1, 8'hFF);
    endtask

    initial begin
        step();
        mon_en = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(2);
        // single reference frame
        beat(64'h0011223344550A0B, 1'b1, 1'b0, 8'hFF);
        beat(64'h0C0D0E0F08000000, 1'b0, 1'b1, 8'hFF);
        idle(5);
        // runts: single-beat frame, and a 12-byte frame
        beat(rnd64(), 1'b1, 1'b1, 8'hFF);
        idle(4);
        beat(rnd64(), 1'b1, 1'b0, 8'hFF);
        beat(rnd64(), 1'b0, 1'b1, 8'hF0);
        idle(4);
        // exactly 14 bytes is a complete header
        beat(rnd64(), 1'b1, 1'b0, 8'hFF);
        beat(rnd64(), 1'b0, 1'b1, 8'hFC);
        idle(4);
        // back-to-back minimum frames
        repeat (3) frame2();
        idle(10);
        // sustained burst overruns the pending slot
        repeat (6) frame2();
        idle(15);
        // stall between beats
        beat(rnd64(), 1'b1, 1'b0, 8'hFF);
        idle(5);
        beat(rnd64(), 1'b0, 1'b1, 8'hFF);
        idle(5);
        // restart during the second header beat
        beat(rnd64(), 1'b1, 1'b0, 8'hFF);
        beat(rnd64(), 1'b1, 1'b0, 8'hFF);
        beat(rnd64(), 1'b0, 1'b0, 8'hFF);
        beat(rnd64(), 1'b0, 1'b1, 8'hFF);
        idle(5);
        // reset mid-header, then a normal frame
        beat(rnd64(), 1'b1, 1'b0, 8'hFF);
        rst = 1'b1;
        step();
        rst = 1'b0;
        beat(rnd64(), 1'b0, 1'b1, 8'hFF);
        frame2();
        idle(5);
        // reset with a header waiting in the slot
        frame2();
        frame2();
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle(4);
        frame2();
        idle(5);
        // randomized traffic
        for (int f = 0; f < 400; f++) begin
            automatic int nbt = $urandom_range(1, 5);
            for (int b = 0; b < nbt; b++) begin
                automatic logic s = (b == 0) || ($urandom_range(0, 19) == 0);
                automatic logic e = (b == nbt - 1);
                automatic logic [7:0] be = e ? 8'(8'hFF << $urandom_range(0, 7)) : 8'hFF;
                if (b > 0 && $urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
                beat(rnd64(), s, e, be);
            end
            if ($urandom_range(0, 5) == 0) beat(rnd64(), 1'b0, 1'($urandom_range(0, 1)), 8'hFF);
            if ($urandom_range(0, 59) == 0) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
            end
            idle($urandom_range(0, 2));
        end
        idle(40);
        chk("drain_vld", 128'(iq.size()), 128'd0);
        chk("drain_runt", 128'(rq.size()), 128'd0);
        chk("drain_ovf", 128'(oq.size()), 128'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/fmac_rx_hdr_extract.md
# fmac_rx_hdr_extract

Receive-side Ethernet header extractor that sits directly upstream of the source-address filter. It parses the 64-bit RX beat stream from the MAC and captures destination address, source address and EtherType of each frame. It presents them with a single-cycle `mac_saddr_vld` strobe, paced so the downstream 3-cycle filter state machine never sees a strobe while busy.

## Interface
Parameters:
- `MIN_GAP`, 3: minimum cycles between consecutive `mac_saddr_vld` pulses; legal range 1–15.

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  synchronous reset, active-high
- `rx_data`  in  64  beat data; byte 0 of beat at [63:56], byte 7 at [7:0]
- `rx_vld`  in  1  beat valid; beats with `rx_vld`=0 are ignored (stall)
- `rx_sop`  in  1  first beat of frame (qualified by `rx_vld`)
- `rx_eop`  in  1  last beat of frame (qualified by `rx_vld`)
- `rx_be`  in  8  byte enables on eop beat, MSB-contiguous (`rx_be[7]` = byte 0); all-ones otherwise
- `mac_daddr`  out  48  destination address, first octet at [47:40]
- `mac_saddr`  out  48  source address, first octet at [47:40]
- `mac_etype`  out  16  EtherType/length
- `mac_saddr_vld`  out  1  one-cycle strobe; the three outputs above are valid
- `hdr_runt`  out  1  one-cycle pulse: frame ended or restarted before 14 header bytes
- `hdr_ovf`  out  1  one-cycle pulse: completed header dropped, pending slot full
- `hdr_cnt`  out  16  count of headers issued on `mac_saddr_vld`, saturates at 16'hFFFF

## Operation
- Parse FSM states: IDLE, HDR1, BODY.
- IDLE: on `rx_vld & rx_sop`, capture DA = `rx_data[63:16]` and SA[47:32] = `rx_data[15:0]`. If `rx_eop` is also set, pulse `hdr_runt` and stay in IDLE; otherwise go to HDR1. Non-sop beats in IDLE are ignored.
- HDR1, on a valid beat:
  - `rx_sop`: pulse `hdr_runt`, treat the beat as a new first beat (IDLE rules).
  - Otherwise, capture SA[31:0] = `rx_data[63:32]` and etype = `rx_data[31:16]`.
  - If `rx_eop` and `rx_be[7:2]` != 6'b111111: runt; pulse `hdr_runt`, go to IDLE, no header.
  - Else: header complete. Go to BODY, or to IDLE if `rx_eop`.
- BODY: a valid `rx_eop` returns to IDLE. A valid `rx_sop` is treated as a new first beat, with no runt.
- Issue path:
  - Gap counter `gap_cnt` (4 bits) loads `MIN_GAP-1` on each issue and decrements to 0.
  - A complete header issues when `gap_cnt`==0 and no pending header exists. Otherwise it goes into the one-deep pending slot.
  - Pending issues in the first cycle `gap_cnt`==0.
  - Pending has priority over a header completing in the same cycle; that header takes the pending slot, which is freed by the issue.
  - Header completes while pending is occupied and not issuing: new header is discarded (oldest wins) and `hdr_ovf` pulses.
- On issue: `mac_daddr`/`mac_saddr`/`mac_etype` load and `mac_saddr_vld` pulses. Address outputs hold until the next issue. `hdr_cnt` increments, saturating.

## Timing
- Reset: all outputs 0, FSM IDLE, `gap_cnt`=0, pending empty. Reset mid-frame discards the partial header; the next frame needs a fresh sop.
- Latency: header-completing beat accepted in cycle N gives `mac_saddr_vld` in N+1 when unobstructed.
- Consecutive `mac_saddr_vld` pulses are at least `MIN_GAP` cycles apart, e.g. N+1 then ≥N+4 for `MIN_GAP`=3.
- Pending header issues exactly when `gap_cnt` reaches 0.
- `hdr_runt` and `hdr_ovf` are registered: they pulse the cycle after the offending beat.
- `rx_vld` stalls between beats do not affect parsing. `gap_cnt` keeps counting during stalls.

## Test plan
- Single frame: beat0 = 0x0011223344550A0B, beat1 = 0x0C0D0E0F08000000 (eop, be=FF). Expect DA=001122334455, SA=0A0B0C0D0E0F, etype=0800, vld one cycle after beat1, `hdr_cnt`=1.
- Runts:
  - sop+eop single beat → `hdr_runt` pulse, no vld.
  - 2-beat frame with beat1 be=0xF0 → `hdr_runt` pulse, no vld.
- Back-to-back minimum 2-beat frames, `MIN_GAP`=3: vld at cycles 2, 5, 8; no `hdr_ovf`; outputs match each frame in order.
- Burst of three headers inside one gap window, `MIN_GAP`=8: first and second headers issued, third dropped with one `hdr_ovf` pulse, `hdr_cnt`=2.
- Stalls and aborts:
  - `rx_vld` low 5 cycles between beat0 and beat1 → correct header, vld one cycle after beat1.
  - sop during HDR1 → `hdr_runt`, and the new frame's header is extracted.
- Assert `rst` in HDR1 and with a header pending → all outputs 0 next cycle, no vld. Next frame extracts normally.
